// File: rtl/proc_defs_pkg.sv
// Shared LEGv8 control definitions: FSM state codes, SignExtender/ALU control codes,
// opcode constants and the decoded-class record used by multicycle_control.
package proc_defs;

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_MEM     = 3'd3;
    localparam logic [2:0] ST_WB      = 3'd4;
    localparam logic [2:0] ST_ILLEGAL = 3'd5;

    localparam logic [1:0] SIGN_I  = 2'b00;
    localparam logic [1:0] SIGN_D  = 2'b01;
    localparam logic [1:0] SIGN_B  = 2'b10;
    localparam logic [1:0] SIGN_CB = 2'b11;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_ORR   = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_PASSB = 4'd7;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // Prefixes for opcodes whose low bits belong to the immediate field
    localparam logic [5:0]  OP_B_PFX    = 6'b000101;
    localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
    localparam logic [9:0]  OP_ADDI_PFX = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI_PFX = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI_PFX = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI_PFX = 10'b1011001000;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LDUR, CLS_STUR, CLS_B, CLS_CBZ, CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        op_class_t  cls;
        logic [1:0] sign_op;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg2loc;
    } decode_t;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode -> instruction class and datapath control fields.
// Immediate ALU ops (ADDI/SUBI/ANDI/ORRI) decode only when IMM_ALU_EN is defined.
import proc_defs::*;

module opcode_decode (
    input  logic [10:0] opcode,
    output decode_t     dec
);

    always_comb begin
        dec.cls     = CLS_ILLEGAL;
        dec.sign_op = SIGN_I;
        dec.alu_op  = ALU_AND;
        dec.alu_src = 1'b0;
        dec.reg2loc = 1'b0;
        if (opcode == OP_ADD) begin
            dec.cls    = CLS_R;
            dec.alu_op = ALU_ADD;
        end else if (opcode == OP_SUB) begin
            dec.cls    = CLS_R;
            dec.alu_op = ALU_SUB;
        end else if (opcode == OP_AND) begin
            dec.cls    = CLS_R;
            dec.alu_op = ALU_AND;
        end else if (opcode == OP_ORR) begin
            dec.cls    = CLS_R;
            dec.alu_op = ALU_ORR;
        end else if (opcode == OP_LDUR || opcode == OP_STUR) begin
            dec.cls     = (opcode == OP_LDUR) ? CLS_LDUR : CLS_STUR;
            dec.sign_op = SIGN_D;
            dec.alu_op  = ALU_ADD;
            dec.alu_src = 1'b1;
            // STUR reads Rt as its second register operand
            dec.reg2loc = (opcode == OP_STUR);
        end else if (opcode[10:5] == OP_B_PFX) begin
            dec.cls     = CLS_B;
            dec.sign_op = SIGN_B;
        end else if (opcode[10:3] == OP_CBZ_PFX) begin
            dec.cls     = CLS_CBZ;
            dec.sign_op = SIGN_CB;
            dec.alu_op  = ALU_PASSB;
            dec.reg2loc = 1'b1;
`ifdef IMM_ALU_EN
        end else if (opcode[10:1] == OP_ADDI_PFX || opcode[10:1] == OP_SUBI_PFX ||
                     opcode[10:1] == OP_ANDI_PFX || opcode[10:1] == OP_ORRI_PFX) begin
            dec.cls     = CLS_I;
            dec.sign_op = SIGN_I;
            dec.alu_src = 1'b1;
            if (opcode[10:1] == OP_ADDI_PFX)      dec.alu_op = ALU_ADD;
            else if (opcode[10:1] == OP_SUBI_PFX) dec.alu_op = ALU_SUB;
            else if (opcode[10:1] == OP_ANDI_PFX) dec.alu_op = ALU_AND;
            else                                  dec.alu_op = ALU_ORR;
`endif
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencing FSM: fetch handshake, opcode latch, phase strobes, retire counter.
// Optional macro IMM_ALU_EN enables the immediate ALU instructions in the decoder.
//
// state   | meaning
// FETCH   | request instruction, latch opcode on IMemAck
// DECODE  | present control fields for latched opcode
// EXEC    | ALU phase; B/CBZ retire here
// MEM     | data access until DMemAck; STUR retires here
// WB      | register write-back and retire
// ILLEGAL | unrecognised opcode, Fault held until Reset
import proc_defs::*;

module multicycle_control (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        IMemAck,
    input  logic        DMemAck,
    output logic        IMemReq,
    output logic        DMemReq,
    output logic        IRWrite,
    output logic [1:0]  SignOp,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        Reg2Loc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        InstrDone,
    output logic        Fault,
    output logic [31:0] RetireCount
);

    logic [2:0]  state, state_nxt;
    logic [10:0] op_q;
    logic [31:0] count_q;
    decode_t     dec;

    opcode_decode u_decode (
        .opcode (op_q),
        .dec    (dec)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:   if (IMemAck) state_nxt = ST_DECODE;
            ST_DECODE:  state_nxt = (dec.cls == CLS_ILLEGAL) ? ST_ILLEGAL : ST_EXEC;
            ST_EXEC: begin
                case (dec.cls)
                    CLS_R, CLS_I:       state_nxt = ST_WB;
                    CLS_LDUR, CLS_STUR: state_nxt = ST_MEM;
                    default:            state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM:     if (DMemAck) state_nxt = (dec.cls == CLS_STUR) ? ST_FETCH : ST_WB;
            ST_WB:      state_nxt = ST_FETCH;
            ST_ILLEGAL: state_nxt = ST_ILLEGAL;
            default:    state_nxt = ST_FETCH;
        endcase
    end

    // Every output is forced low while Reset is asserted, including the fetch request
    always_comb begin
        IMemReq  = 1'b0;
        DMemReq  = 1'b0;
        IRWrite  = 1'b0;
        SignOp   = 2'b00;
        ALUOp    = 4'd0;
        ALUSrc   = 1'b0;
        Reg2Loc  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Fault    = 1'b0;
        if (!Reset) begin
            if (state == ST_DECODE || state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
                SignOp  = dec.sign_op;
                ALUOp   = dec.alu_op;
                ALUSrc  = dec.alu_src;
                Reg2Loc = dec.reg2loc;
            end
            case (state)
                ST_FETCH: begin
                    IMemReq = 1'b1;
                    IRWrite = IMemAck;
                end
                ST_EXEC: begin
                    if (dec.cls == CLS_B) begin
                        PCWrite = 1'b1;
                        PCSrc   = 1'b1;
                    end else if (dec.cls == CLS_CBZ) begin
                        PCWrite = 1'b1;
                        PCSrc   = Zero;
                    end
                end
                ST_MEM: begin
                    DMemReq  = 1'b1;
                    MemRead  = (dec.cls == CLS_LDUR);
                    MemWrite = (dec.cls == CLS_STUR);
                    PCWrite  = (dec.cls == CLS_STUR) && DMemAck;
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (dec.cls == CLS_LDUR);
                    PCWrite  = 1'b1;
                end
                ST_ILLEGAL: Fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign InstrDone   = PCWrite;
    assign RetireCount = Reset ? 32'd0 : count_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= ST_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            if (IRWrite) op_q <= Opcode;
            if (PCWrite) count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: randomized instruction stream against a
// per-instruction reference model of retire timing and control fields.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [10:0] Opcode;
    logic        Zero, IMemAck, DMemAck;
    logic        IMemReq, DMemReq, IRWrite;
    logic [1:0]  SignOp;
    logic [3:0]  ALUOp;
    logic        ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite;
    logic        PCWrite, PCSrc, InstrDone, Fault;
    logic [31:0] RetireCount;

    multicycle_control dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
        .IMemAck(IMemAck), .DMemAck(DMemAck), .IMemReq(IMemReq), .DMemReq(DMemReq),
        .IRWrite(IRWrite), .SignOp(SignOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .Reg2Loc(Reg2Loc), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .InstrDone(InstrDone),
        .Fault(Fault), .RetireCount(RetireCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cycles;
        bit         pcsrc;
        bit [1:0]   sign_op;
        bit         chk_sign;
        bit [3:0]   alu_op;
        bit         chk_alu;
        bit         alu_src;
        bit         chk_src;
        bit         r2l;
        bit         chk_r2l;
        bit         regwrite;
        bit         memtoreg;
        int         rd_cycles;
        int         wr_cycles;
        logic [31:0] count_before;
    } exp_t;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_B = 4, K_CB = 5;

    exp_t        expq[$];
    int          checks = 0, failures = 0;
    int          n_ret = 0;
    int          iwait = 0, dwait = 0;
    bit          idle = 1'b0, force_iack = 1'b0;
    logic [31:0] model_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: instruction semantics by mnemonic, timing as base CPI plus ack waits
    function automatic bit model(input logic [10:0] op, input int iw, input int dw,
                                 input bit z, output exp_t e);
        int kind = -1;
        int alu = 0;
        e = '{default: 0};
        if (op == 11'b10001011000)           begin kind = K_R; alu = 2; end
        else if (op == 11'b11001011000)      begin kind = K_R; alu = 6; end
        else if (op == 11'b10001010000)      begin kind = K_R; alu = 0; end
        else if (op == 11'b10101010000)      begin kind = K_R; alu = 1; end
        else if (op == 11'b11111000010)      kind = K_LD;
        else if (op == 11'b11111000000)      kind = K_ST;
        else if (op[10:5] == 6'b000101)      kind = K_B;
        else if (op[10:3] == 8'b10110100)    kind = K_CB;
`ifdef IMM_ALU_EN
        else if (op[10:1] == 10'b1001000100) begin kind = K_I; alu = 2; end
        else if (op[10:1] == 10'b1101000100) begin kind = K_I; alu = 6; end
        else if (op[10:1] == 10'b1001001000) begin kind = K_I; alu = 0; end
        else if (op[10:1] == 10'b1011001000) begin kind = K_I; alu = 1; end
`endif
        case (kind)
            K_R: begin
                e.cycles = 4 + iw; e.alu_op = 4'(alu); e.chk_alu = 1; e.chk_src = 1; e.regwrite = 1;
            end
            K_I: begin
                e.cycles = 4 + iw; e.alu_op = 4'(alu); e.chk_alu = 1; e.alu_src = 1; e.chk_src = 1;
                e.sign_op = 2'b00; e.chk_sign = 1; e.regwrite = 1;
            end
            K_LD: begin
                e.cycles = 5 + iw + dw; e.sign_op = 2'b01; e.chk_sign = 1; e.alu_op = 2; e.chk_alu = 1;
                e.alu_src = 1; e.chk_src = 1; e.regwrite = 1; e.memtoreg = 1; e.rd_cycles = dw + 1;
            end
            K_ST: begin
                e.cycles = 4 + iw + dw; e.sign_op = 2'b01; e.chk_sign = 1; e.alu_op = 2; e.chk_alu = 1;
                e.alu_src = 1; e.chk_src = 1; e.wr_cycles = dw + 1;
            end
            K_B: begin
                e.cycles = 3 + iw; e.sign_op = 2'b10; e.chk_sign = 1; e.pcsrc = 1;
            end
            K_CB: begin
                e.cycles = 3 + iw; e.sign_op = 2'b11; e.chk_sign = 1; e.alu_op = 7; e.chk_alu = 1;
                e.r2l = 1; e.chk_r2l = 1; e.pcsrc = z;
            end
            default: ;
        endcase
        return kind >= 0;
    endfunction

    // Memory responders: ack after the configured number of wait cycles
    int icnt = 0, dcnt = 0;
    initial begin
        IMemAck = 1'b0;
        DMemAck = 1'b0;
        forever begin
            @(negedge CLK);
            if (!Reset && !idle && IMemReq) begin
                IMemAck = force_iack || (icnt == iwait);
                icnt++;
            end else begin
                IMemAck = force_iack;
                icnt = 0;
            end
            if (!Reset && DMemReq) begin
                DMemAck = (dcnt == dwait);
                dcnt++;
            end else begin
                DMemAck = 1'b0;
                dcnt = 0;
            end
        end
    end

    // Monitor: pops the expected retire record whenever InstrDone is seen
    initial begin
        int   cyc = 0, start = 0, rd = 0, wr = 0;
        bit   new_instr = 1;
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (Reset) begin
                new_instr = 1;
            end else begin
                cyc++;
                if (new_instr) begin
                    start = cyc; rd = 0; wr = 0; new_instr = 0;
                end
                if (MemRead)  rd++;
                if (MemWrite) wr++;
                chk("pcwrite_vs_instrdone", PCWrite, InstrDone);
                if (InstrDone) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("retire_cycles", cyc - start + 1, e.cycles);
                        chk("pcsrc", PCSrc, e.pcsrc);
                        chk("regwrite", RegWrite, e.regwrite);
                        chk("memtoreg", MemtoReg, e.memtoreg);
                        chk("memread_cycles", rd, e.rd_cycles);
                        chk("memwrite_cycles", wr, e.wr_cycles);
                        chk("retirecount_before", RetireCount, e.count_before);
                        if (e.chk_sign) chk("signop", SignOp, e.sign_op);
                        if (e.chk_alu)  chk("aluop", ALUOp, e.alu_op);
                        if (e.chk_src)  chk("alusrc", ALUSrc, e.alu_src);
                        if (e.chk_r2l)  chk("reg2loc", Reg2Loc, e.r2l);
                    end
                    n_ret++;
                    new_instr = 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK); #2;
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #2;
            chk("reset_outputs_zero", {IMemReq, DMemReq, IRWrite, SignOp, ALUOp, ALUSrc, Reg2Loc,
                MemRead, MemWrite, MemtoReg, RegWrite, PCWrite, PCSrc, InstrDone, Fault}, 0);
            chk("reset_count_zero", RetireCount, 0);
        end
        Reset = 1'b0;
        #1;
        chk("imemreq_after_release", IMemReq, 1);
        chk("count_after_release", RetireCount, 0);
        chk("fault_after_release", Fault, 0);
        model_count = 0;
    endtask

    task automatic run_instr(input logic [10:0] op, input int iw, input int dw, input bit z);
        exp_t e;
        int   target;
        void'(model(op, iw, dw, z, e));
        e.count_before = model_count;
        Opcode = op; iwait = iw; dwait = dw; Zero = z;
        expq.push_back(e);
        target = n_ret + 1;
        for (int k = 0; k < 60 && n_ret < target; k++) begin
            @(negedge CLK); #2;
        end
        if (n_ret < target) begin
            chk("retire_timeout", 0, 1);
            expq.delete();
        end
        model_count++;
    endtask

    task automatic check_illegal(input logic [10:0] op);
        Opcode = op; iwait = 0; force_iack = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge CLK); #2;
            if (c == 2) chk("fault_not_yet", Fault, 0);
            if (c >= 3) begin
                chk("fault_sticky", Fault, 1);
                chk("illegal_strobes_low", {IMemReq, DMemReq, PCWrite, RegWrite, InstrDone}, 0);
                force_iack = 1'b1;
            end
        end
        force_iack = 1'b0;
        do_reset();
    endtask

    function automatic logic [10:0] pick_op(input int k);
        logic [10:0] op;
        case (k)
            0: op = 11'b10001011000;
            1: op = 11'b11001011000;
            2: op = 11'b10001010000;
            3: op = 11'b10101010000;
            4: op = 11'b11111000010;
            5: op = 11'b11111000000;
            6: op = {6'b000101, 5'($urandom)};
            7: op = {8'b10110100, 3'($urandom)};
            8: op = {10'b1001000100, 1'($urandom)};
            9: op = {10'b1101000100, 1'($urandom)};
            10: op = {10'b1001001000, 1'($urandom)};
            default: op = {10'b1011001000, 1'($urandom)};
        endcase
        return op;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        scratch;
        logic [10:0] op;
        int          issued;
        Reset = 1'b1; Opcode = '0; Zero = 1'b0;
        do_reset();

        run_instr(11'b10001011000, 0, 0, 0);   // ADD
        run_instr(11'b11111000010, 0, 2, 0);   // LDUR, delayed data ack
        run_instr(11'b10110100101, 0, 0, 1);   // CBZ taken
        run_instr(11'b10110100010, 0, 0, 0);   // CBZ not taken
        run_instr(11'b11111000000, 1, 0, 0);   // STUR
        run_instr(11'b00010111011, 0, 0, 0);   // B

        issued = 0;
        while (issued < 40) begin
            op = pick_op($urandom_range(0, 11));
            if (model(op, 0, 0, 0, scratch)) begin
                run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
                issued++;
            end
        end

        idle = 1'b1;
        @(negedge CLK); #2;
        chk("final_retirecount", RetireCount, model_count);
        idle = 1'b0;
        do_reset();

        if (model(11'b10010001000, 0, 0, 0, scratch))
            run_instr(11'b10010001000, 0, 0, 0);   // ADDI
        else
            check_illegal(11'b10010001000);

        check_illegal(11'b11111111111);

        chk("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
